// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin front end that shares one external
// combinational W-bit adder among NREQ requesters. A grant is taken in IDLE,
// the operands are registered (ISSUE), and the sum is captured and held in
// RESP until the consumer accepts it.
// Optional feature: define ADDER_RR_ARBITER_SUB_EN to add a per-requester
// req_sub input that selects a - b (b inverted, carry-in forced to 1).
module adder_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
`ifdef ADDER_RR_ARBITER_SUB_EN
  input  logic [NREQ-1:0]   req_sub,
`endif
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic [1:0]        add_c,
  input  logic [W-1:0]      add_sum,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_cout,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic           grant_any;

  logic [W-1:0]   a_p0;
  logic [W-1:0]   b_p0;
  logic           cin_p0;
  logic [IDW-1:0] id_p0;
  logic [W-1:0]   b_eff;
  logic           cin_eff;
`ifdef ADDER_RR_ARBITER_SUB_EN
  logic           sub_p0;
`endif

  // Carry-out recovered from the operand and sum MSBs only, since the
  // external adder exposes no carry output.
  function automatic logic carry_out(input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic [W-1:0] s);
    return (a[W-1] & b[W-1]) | ((a[W-1] ^ b[W-1]) & ~s[W-1]);
  endfunction

  // Round-robin search: first valid requester after the last winner, with wrap.
  always_comb begin
    winner    = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_any && req_valid[(int'(ptr) + k) % NREQ]) begin
        grant_any = 1'b1;
        winner    = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Next-state and grant strobe; a grant is only offered in IDLE.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_any && rst_n) begin
          req_ready = NREQ'(1) << winner;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- stage p0: operands of the granted requester are registered ----
  // Latch winner's operands and advance the round-robin pointer on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= IDW'(NREQ - 1);
      a_p0   <= '0;
      b_p0   <= '0;
      cin_p0 <= 1'b0;
      id_p0  <= '0;
`ifdef ADDER_RR_ARBITER_SUB_EN
      sub_p0 <= 1'b0;
`endif
    end else if (state == IDLE && grant_any) begin
      ptr    <= winner;
      a_p0   <= req_a[int'(winner)*W +: W];
      b_p0   <= req_b[int'(winner)*W +: W];
      cin_p0 <= req_cin[winner];
      id_p0  <= winner;
`ifdef ADDER_RR_ARBITER_SUB_EN
      sub_p0 <= req_sub[winner];
`endif
    end
  end

  // Subtraction is a + ~b + 1; the requester's own carry-in is then ignored.
`ifdef ADDER_RR_ARBITER_SUB_EN
  assign b_eff   = sub_p0 ? ~b_p0 : b_p0;
  assign cin_eff = sub_p0 | cin_p0;
`else
  assign b_eff   = b_p0;
  assign cin_eff = cin_p0;
`endif

  assign add_a = a_p0;
  assign add_b = b_eff;
  assign add_c = {2{cin_eff}};
  assign busy  = (state != IDLE);

  // ---- stage p1: adder result captured and held until consumed ----
  // Capture the sum at the end of ISSUE; drop valid once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else if (state == ISSUE) begin
      rsp_valid <= 1'b1;
      rsp_data  <= add_sum;
      rsp_cout  <= carry_out(add_a, add_b, add_sum);
      rsp_id    <= id_p0;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed, table-driven bench for adder_rr_arbiter with
// a behavioural model of the external combinational adder.
module tb_adder_rr_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [1:0]        add_c;
  logic [W-1:0]      add_sum;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  // External shared adder: sum = a + b + carry, carry taken from add_c.
  assign add_sum = add_a + add_b + {{(W-1){1'b0}}, add_c[0]};

  adder_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADDER_RR_ARBITER_SUB_EN
    .req_sub   (req_sub),
`endif
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 99;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated transaction with rsp_ready high: grant, ISSUE, RESP, back to IDLE.
  task automatic txn(input int id, input logic [15:0] a, input logic [15:0] b,
                     input logic cin, input logic sub,
                     input logic [15:0] exp_sum, input logic exp_cout);
    logic [15:0] exp_b;
    exp_b = sub ? ~b : b;
    @(negedge clk);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_cin[id]      = cin;
    req_sub[id]      = sub;
    req_valid        = 4'b0001 << id;
    rsp_ready        = 1'b1;
    #1 check("grant", req_ready, 32'(4'b0001 << id));
    check("idle_busy", busy, 0);
    @(negedge clk);
    req_valid = '0;
    #1 check("issue_busy", busy, 1);
    check("issue_rsp_valid", rsp_valid, 0);
    check("issue_req_ready", req_ready, 0);
    check("issue_add_a", add_a, a);
    check("issue_add_b", add_b, exp_b);
    check("issue_add_c", add_c, (cin | sub) ? 2'b11 : 2'b00);
    @(negedge clk);
    #1 check("resp_valid", rsp_valid, 1);
    check("resp_data", rsp_data, exp_sum);
    check("resp_cout", rsp_cout, exp_cout);
    check("resp_id", rsp_id, id);
    @(negedge clk);
    #1 check("done_valid", rsp_valid, 0);
    check("done_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order[5];
    int cyc;

    vecs[0] = '{0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{2, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[4] = '{0, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0};
    vecs[5] = '{3, 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
    vecs[6] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    order   = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;

    // Reset state
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_c", add_c, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single transactions
    for (int i = 0; i < 7; i++)
      txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].sum, vecs[i].cout);

    // Round-robin with all requesters valid, starting from a fresh pointer
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 16'(i * 16'h0101);
      req_b[i*W +: W] = 16'h0001;
      req_cin[i]      = 1'b0;
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      cyc = 0;
      while (req_ready == '0 && cyc < 12) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check("rr_grant", oh2idx(req_ready), order[g]);
      @(negedge clk);
      #1;
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Backpressure in RESP
    do_reset();
    req_a[0*W +: W] = 16'h0100;
    req_b[0*W +: W] = 16'h0023;
    req_a[2*W +: W] = 16'h1111;
    req_b[2*W +: W] = 16'h2222;
    req_cin   = '0;
    rsp_ready = 1'b0;
    req_valid = 4'b0101;
    #1 check("bp_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    #1 check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_data", rsp_data, 16'h0123);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 check("bp_hold_ready", req_ready, 0);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_data, 16'h0123);
      check("bp_hold_id", rsp_id, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 check("bp_next_grant", req_ready, 4'b0100);
    check("bp_released", rsp_valid, 0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1 check("bp_second_data", rsp_data, 16'h3333);
    check("bp_second_id", rsp_id, 2);
    check("bp_second_cout", rsp_cout, 0);
    @(negedge clk);

    // Reset asserted during ISSUE
    @(negedge clk);
    req_a[1*W +: W] = 16'hAAAA;
    req_b[1*W +: W] = 16'h1111;
    req_cin[1]      = 1'b1;
    req_valid       = 4'b0010;
    #1 check("mid_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1 check("mid_in_issue", busy, 1);
    rst_n = 1'b0;
    #1 check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_add_a", add_a, 0);
    check("mid_rst_add_c", add_c, 0);
    check("mid_rst_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 check("mid_no_rsp", rsp_valid, 0);
    end
    req_valid = 4'b1111;
    #1 check("mid_ptr_restart", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

`ifdef ADDER_RR_ARBITER_SUB_EN
    // Subtraction
    txn(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    txn(1, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one instance of the 16-bit recursive-doubling prefix adder among NREQ requesters.
- Round-robin arbitration, valid/ready handshake on both sides.
- Operands are registered, then driven to the external combinational adder; the sum is captured and held until consumed.
- Sits between ALU-side clients (PC increment, address generation, ALU ops) and the shared adder.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 16, operand/sum width; must match adder width
- IDW, 2, requester index width; must satisfy 2**IDW >= NREQ

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_a  input  NREQ*W  operand A, requester i at [i*W +: W]
- req_b  input  NREQ*W  operand B, same packing
- req_cin  input  NREQ  carry-in per requester
- req_ready  output  NREQ  one-hot grant/accept strobe
- add_a  output  W  to adder operand a
- add_b  output  W  to adder operand b
- add_c  output  2  to adder carry-in code: 2'b00 = carry 0 (kill), 2'b11 = carry 1 (generate); other codes never driven
- add_sum  input  W  from adder sum output
- rsp_valid  output  1  result valid
- rsp_ready  input  1  result consumer ready
- rsp_data  output  W  captured sum
- rsp_cout  output  1  carry-out, derived from MSBs
- rsp_id  output  IDW  index of the requester that owns the result
- busy  output  1  high when state != IDLE

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; last-grant pointer = NREQ-1, so requester 0 has first priority.
  - Operand registers, rsp_data, rsp_cout, rsp_id = 0; rsp_valid = 0; req_ready = 0.
  - add_a/add_b = 0, add_c = 2'b00.
- FSM states:
  - IDLE:
    - Winner = first i with req_valid[i], searching from pointer+1 upward with wrap.
    - req_ready[winner] = 1, combinational, only in IDLE. All other bits 0; all bits 0 if no request.
    - On the clock edge with a grant: latch a, b, cin and id into operand registers; pointer = winner; go to ISSUE.
  - ISSUE:
    - add_a/add_b/add_c are driven from the operand registers, so the adder path is register-to-register.
    - At the edge: rsp_data = add_sum; rsp_cout = (a[W-1]&b[W-1]) | ((a[W-1]^b[W-1]) & ~add_sum[W-1]); rsp_id = id; rsp_valid = 1; go to RESP.
  - RESP:
    - rsp_valid = 1; outputs held stable.
    - At an edge with rsp_ready = 1: rsp_valid = 0; go to IDLE.
- Outside ISSUE: add_a/add_b hold the operand-register values (no toggling requirement); add_c follows the registered cin.
- Latency: acceptance edge T → rsp_valid high after edge T+1. Peak throughput is 1 result per 3 cycles, achieved with rsp_ready held high.
- No grant occurs in ISSUE or RESP; requests wait with req_valid held. A requester may drop req_valid before it is granted without side effect.
- Fairness: any continuously asserted requester is granted within NREQ grants.
- Arithmetic is modulo 2^W; overflow is visible only via rsp_cout.
- Reset asserted mid-transaction discards the transaction; no response is produced after reset.
- rsp_ready asserted in IDLE or ISSUE is ignored.

Optional Feature:
- Macro ADDER_RR_ARBITER_SUB_EN.
- Defined:
  - Adds input port req_sub [NREQ], latched with the operands.
  - When set: add_b = ~b and add_c = 2'b11, so result = a - b mod 2^W.
  - rsp_cout = 1 means no borrow; rsp_cout is computed using the inverted b.
- Undefined: port absent; addition only.

Test Plan:
- Single add: req0 a=16'h1234, b=16'h0FFF, cin=0 → rsp_valid 2 cycles after accept, rsp_data=16'h2233, rsp_cout=0, rsp_id=0.
- Carry/overflow: a=16'hFFFF, b=16'h0000, cin=1 → rsp_data=16'h0000, rsp_cout=1; add_c observed as 2'b11 during ISSUE.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0; each granted once in any 4 consecutive grants.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_data/rsp_id stable, req_ready stays 0; release → IDLE, next grant one cycle later.
- Reset mid-op: assert rst_n=0 during ISSUE → all outputs zero immediately (async), rsp_valid never rises for that request, pointer restarts at requester 0.
- SUB_EN: a=16'h0005, b=16'h0007, sub=1 → rsp_data=16'hFFFE, rsp_cout=0; a=7, b=5 → 16'h0002, rsp_cout=1.
